alu_exec_unit: RTL and testbench

- Execute-stage ALU. Consumes the 5-bit ALU operation code from the ALU control decoder, together with two operands, and produces a registered result and a zero flag for the EX/MEM boundary.
- Single-cycle ops: ADD, SUB, MOV, JUMP.
- MUL is iterative and holds the stage busy for MUL_CYCLES cycles.
- Valid/ready handshakes on both sides; a flush input aborts in-flight work (exception, IRET).

---
 rtl/alu_exec_unit.sv | 136 +++++++++++++
 tb/tb_alu_exec_unit.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU for the EX/MEM boundary: single-cycle ADD/SUB/MOV/JUMP,
// multi-cycle MUL, valid/ready handshakes on both sides and a flush abort.
module alu_exec_unit #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       aluop,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal
);

  localparam logic [4:0] ALUOP_ADD  = 5'h01;
  localparam logic [4:0] ALUOP_SUB  = 5'h02;
  localparam logic [4:0] ALUOP_MUL  = 5'h03;
  localparam logic [4:0] ALUOP_MOV  = 5'h04;
  localparam logic [4:0] ALUOP_JUMP = 5'h05;
  localparam int         CW         = $clog2(MUL_CYCLES);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t           r_state, w_state_nxt;
  logic [CW-1:0]    r_count, w_count_nxt;
  logic [WIDTH-1:0] r_op_a, r_op_b, r_result;
  logic             r_out_valid, r_zero, r_illegal;

  logic             w_slot_free, w_accept, w_latch, w_write, w_out_valid_nxt;
  logic             w_alu_illegal, w_wr_illegal;
  logic [WIDTH-1:0] w_alu_res, w_wr_res, w_product;

  // Low WIDTH bits only; signed and unsigned products agree there.
  assign w_product = r_op_a * r_op_b;

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    w_alu_res     = '0;
    w_alu_illegal = 1'b0;
    case (aluop)
      ALUOP_ADD:  w_alu_res = op_a + op_b;
      ALUOP_SUB:  w_alu_res = op_a - op_b;
      ALUOP_MOV,
      ALUOP_JUMP: w_alu_res = op_b;
      default:    w_alu_illegal = 1'b1;
    endcase
  end

  always_comb begin
    w_slot_free  = !r_out_valid || out_ready;
    in_ready     = !flush && (r_state == S_IDLE) && w_slot_free;
    w_accept     = in_valid && in_ready;
    w_state_nxt  = r_state;
    w_count_nxt  = r_count;
    w_latch      = 1'b0;
    w_write      = 1'b0;
    w_wr_res     = '0;
    w_wr_illegal = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (aluop == ALUOP_MUL) begin
            w_latch     = 1'b1;
            w_count_nxt = CW'(MUL_CYCLES - 1);
            w_state_nxt = S_BUSY;
          end else begin
            w_write      = 1'b1;
            w_wr_res     = w_alu_res;
            w_wr_illegal = w_alu_illegal;
          end
        end
      end
      S_BUSY: begin
        if (r_count != '0) begin
          w_count_nxt = r_count - CW'(1);
        end else if (w_slot_free) begin
          w_write     = 1'b1;
          w_wr_res    = w_product;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // A fresh write keeps the slot full; otherwise a handshake empties it.
    w_out_valid_nxt = w_write ? 1'b1 : (out_ready ? 1'b0 : r_out_valid);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_count     <= '0;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_zero      <= 1'b0;
      r_illegal   <= 1'b0;
    end else if (flush) begin
      r_state     <= S_IDLE;
      r_count     <= '0;
      r_out_valid <= 1'b0;
      r_illegal   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_count     <= w_count_nxt;
      r_out_valid <= w_out_valid_nxt;
      if (w_write) begin
        r_result  <= w_wr_res;
        r_zero    <= (w_wr_res == '0);
        r_illegal <= w_wr_illegal;
      end
    end
  end

  // NOTE: operand registers carry no reset; they are only read in BUSY, after a MUL accept loaded them.
  always_ff @(posedge clk) begin
    if (w_latch) begin
      r_op_a <= op_a;
      r_op_b <= op_b;
    end
  end

  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign zero      = r_zero;
  assign illegal   = r_illegal;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed scenarios followed by a
// randomized phase scored against an arithmetic reference model.
module tb_alu_exec_unit;

  localparam int         WIDTH      = 32;
  localparam int         MUL_CYCLES = 5;
  localparam logic [4:0] OP_ADD     = 5'h01;
  localparam logic [4:0] OP_SUB     = 5'h02;
  localparam logic [4:0] OP_MUL     = 5'h03;
  localparam logic [4:0] OP_MOV     = 5'h04;
  localparam logic [4:0] OP_JUMP    = 5'h05;

  logic             clk = 1'b0;
  logic             reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [4:0]       aluop;
  logic [WIDTH-1:0] op_a, op_b, result;
  logic             zero, illegal;

  int vectors     = 0;
  int miscompares = 0;

  logic [WIDTH-1:0] exp_res_q[$];
  logic             exp_ill_q[$];

  always #5 clk = ~clk;

  alu_exec_unit #(.WIDTH(WIDTH), .MUL_CYCLES(MUL_CYCLES)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .aluop     (aluop),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .illegal   (illegal)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] op, input logic [WIDTH-1:0] a,
                       input logic [WIDTH-1:0] b, input logic ordy);
    in_valid  = v;
    aluop     = op;
    op_a      = a;
    op_b      = b;
    out_ready = ordy;
    #1;
  endtask

  // Reference model: what the operation means, modulo 2^WIDTH.
  function automatic logic [WIDTH-1:0] ref_result(input logic [4:0] op, input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
    longint unsigned p;
    case (op)
      OP_ADD:  return WIDTH'((longint'(a) + longint'(b)) % (64'd1 << WIDTH));
      OP_SUB:  return WIDTH'((longint'(a) + (64'd1 << WIDTH) - longint'(b)) % (64'd1 << WIDTH));
      OP_MOV:  return b;
      OP_JUMP: return b;
      OP_MUL: begin
        p = longint'(a) * longint'(b);
        return WIDTH'(p % (64'd1 << WIDTH));
      end
      default: return '0;
    endcase
  endfunction

  function automatic logic ref_illegal(input logic [4:0] op);
    return !(op inside {OP_ADD, OP_SUB, OP_MUL, OP_MOV, OP_JUMP});
  endfunction

  // One cycle of the random phase: score a retiring result, record an accept.
  task automatic score_cycle(input string tag);
    logic [WIDTH-1:0] er;
    logic             ei;
    if (out_valid && out_ready) begin
      if (exp_res_q.size() == 0) begin
        check({tag, "_spurious_valid"}, 64'(out_valid), 64'd0);
      end else begin
        er = exp_res_q.pop_front();
        ei = exp_ill_q.pop_front();
        check({tag, "_result"},  64'(result),  64'(er));
        check({tag, "_zero"},    64'(zero),    64'(er == '0));
        check({tag, "_illegal"}, 64'(illegal), 64'(ei));
      end
    end
    if (in_valid && in_ready) begin
      exp_res_q.push_back(ref_result(aluop, op_a, op_b));
      exp_ill_q.push_back(ref_illegal(aluop));
    end
  endtask

  initial begin
    logic [4:0]       rop;
    logic [WIDTH-1:0] ra, rb;
    int               sel;

    reset = 1'b1; flush = 1'b0;
    drive(1'b0, 5'h00, '0, '0, 1'b1);
    tick(); tick();
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_result",    64'(result),    64'd0);
    check("reset_zero",      64'(zero),      64'd0);
    check("reset_illegal",   64'(illegal),   64'd0);
    reset = 1'b0;
    #1;
    check("post_reset_in_ready", 64'(in_ready), 64'd1);

    // ADD wraps to zero.
    drive(1'b1, OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1);
    check("add_in_ready", 64'(in_ready), 64'd1);
    tick();
    drive(1'b0, OP_ADD, '0, '0, 1'b1);
    check("add_out_valid", 64'(out_valid), 64'd1);
    check("add_result",    64'(result),    64'd0);
    check("add_zero",      64'(zero),      64'd1);
    check("add_illegal",   64'(illegal),   64'd0);
    tick();

    // Back-to-back single-cycle ops.
    drive(1'b1, OP_SUB, 32'd5, 32'd5, 1'b1);
    check("b2b_sub_in_ready", 64'(in_ready), 64'd1);
    tick();
    check("b2b_sub_result", 64'(result), 64'd0);
    check("b2b_sub_zero",   64'(zero),   64'd1);
    drive(1'b1, OP_MOV, 32'hDEAD, 32'h0000_1234, 1'b1);
    check("b2b_mov_in_ready", 64'(in_ready), 64'd1);
    tick();
    check("b2b_mov_valid",  64'(out_valid), 64'd1);
    check("b2b_mov_result", 64'(result),    64'h1234);
    check("b2b_mov_zero",   64'(zero),      64'd0);
    drive(1'b1, OP_JUMP, 32'h0, 32'h0040_0020, 1'b1);
    check("b2b_jump_in_ready", 64'(in_ready), 64'd1);
    tick();
    check("b2b_jump_result", 64'(result), 64'h0040_0020);
    drive(1'b0, OP_ADD, '0, '0, 1'b1);
    tick();
    check("b2b_drained", 64'(out_valid), 64'd0);

    // MUL latency, with an ADD held at the input that must not be taken.
    drive(1'b1, OP_MUL, 32'h0001_0003, 32'h0002_0005, 1'b1);
    check("mul1_in_ready", 64'(in_ready), 64'd1);
    tick();
    drive(1'b1, OP_ADD, 32'h1, 32'h1, 1'b1);
    for (int i = 0; i < MUL_CYCLES; i++) begin
      check($sformatf("mul1_busy_in_ready_%0d", i), 64'(in_ready), 64'd0);
      check($sformatf("mul1_busy_valid_%0d", i),    64'(out_valid), 64'd0);
      tick();
    end
    check("mul1_valid",   64'(out_valid), 64'd1);
    check("mul1_result",  64'(result),    64'h000B_000F);
    check("mul1_illegal", 64'(illegal),   64'd0);
    drive(1'b1, OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    check("mul2_in_ready", 64'(in_ready), 64'd1);
    tick();
    drive(1'b0, OP_ADD, '0, '0, 1'b1);
    check("mul2_accept_clears_valid", 64'(out_valid), 64'd0);
    repeat (MUL_CYCLES) tick();
    check("mul2_valid",  64'(out_valid), 64'd1);
    check("mul2_result", 64'(result),    64'h1);

    // MUL result held by a stalled consumer, then retired alongside a new accept.
    drive(1'b1, OP_MUL, 32'd3, 32'd4, 1'b1);
    tick();
    drive(1'b0, OP_ADD, '0, '0, 1'b0);
    repeat (MUL_CYCLES) tick();
    check("stall_mul_valid",  64'(out_valid), 64'd1);
    check("stall_mul_result", 64'(result),    64'd12);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, OP_ADD, 32'd10, 32'd20, 1'b0);
      check($sformatf("stall_in_ready_%0d", i), 64'(in_ready),  64'd0);
      tick();
      check($sformatf("stall_valid_%0d", i),    64'(out_valid), 64'd1);
      check($sformatf("stall_result_%0d", i),   64'(result),    64'd12);
    end
    drive(1'b1, OP_ADD, 32'd10, 32'd20, 1'b1);
    check("stall_release_in_ready", 64'(in_ready), 64'd1);
    tick();
    drive(1'b0, OP_ADD, '0, '0, 1'b1);
    check("replace_valid",  64'(out_valid), 64'd1);
    check("replace_result", 64'(result),    64'd30);
    tick();

    // Flush in the second cycle of a MUL.
    drive(1'b1, OP_MUL, 32'd7, 32'd6, 1'b1);
    tick();
    drive(1'b0, OP_ADD, '0, '0, 1'b1);
    tick();
    flush = 1'b1;
    drive(1'b1, OP_ADD, 32'd1, 32'd2, 1'b1);
    check("flush_in_ready", 64'(in_ready), 64'd0);
    tick();
    flush = 1'b0;
    drive(1'b0, OP_ADD, '0, '0, 1'b1);
    check("flush_valid",    64'(out_valid), 64'd0);
    check("flush_in_ready_after", 64'(in_ready), 64'd1);
    for (int i = 0; i < MUL_CYCLES + 1; i++) begin
      tick();
      check($sformatf("flush_no_result_%0d", i), 64'(out_valid), 64'd0);
    end

    // Reset in the middle of a MUL, with a stale nonzero result present.
    drive(1'b1, OP_ADD, 32'd1, 32'd1, 1'b1);
    tick();
    drive(1'b1, OP_MUL, 32'd9, 32'd9, 1'b1);
    tick();
    drive(1'b0, OP_ADD, '0, '0, 1'b1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("midmul_reset_valid",    64'(out_valid), 64'd0);
    check("midmul_reset_result",   64'(result),    64'd0);
    check("midmul_reset_zero",     64'(zero),      64'd0);
    check("midmul_reset_in_ready", 64'(in_ready),  64'd1);
    repeat (MUL_CYCLES) tick();
    check("midmul_reset_no_result", 64'(out_valid), 64'd0);

    // Unrecognised opcode, then a legal ADD clears illegal.
    drive(1'b1, 5'h1F, 32'd7, 32'd9, 1'b1);
    tick();
    check("illegal_valid",  64'(out_valid), 64'd1);
    check("illegal_flag",   64'(illegal),   64'd1);
    check("illegal_result", 64'(result),    64'd0);
    check("illegal_zero",   64'(zero),      64'd1);
    drive(1'b1, OP_ADD, 32'd2, 32'd3, 1'b1);
    tick();
    check("illegal_cleared", 64'(illegal), 64'd0);
    check("illegal_next",    64'(result),  64'd5);
    drive(1'b0, OP_ADD, '0, '0, 1'b1);
    tick();

    // Randomized traffic scored in order against the reference model.
    for (int cyc = 0; cyc < 300; cyc++) begin
      sel = $urandom_range(0, 9);
      case (sel)
        0, 1, 9: rop = OP_ADD;
        2, 3:    rop = OP_SUB;
        4:       rop = OP_MOV;
        5:       rop = OP_JUMP;
        6, 7:    rop = OP_MUL;
        default: rop = 5'h10 + 5'($urandom_range(0, 15));
      endcase
      ra = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : 32'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? ra : 32'($urandom);
      drive(1'($urandom_range(0, 3) != 0), rop, ra, rb, 1'($urandom_range(0, 3) != 0));
      score_cycle("rand");
      tick();
    end

    // Drain with a bounded cycle budget.
    drive(1'b0, OP_ADD, '0, '0, 1'b1);
    for (int cyc = 0; cyc < 4 * MUL_CYCLES && exp_res_q.size() != 0; cyc++) begin
      score_cycle("drain");
      tick();
    end
    check("drain_outstanding", 64'(exp_res_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
